// File: rtl/aes128_encrypt_iter_if.sv
// ---------------------------------------------------------------------------
// aes128_encrypt_iter_if
// Purpose : start/done handshake and data bus of the iterative AES-128
//           encryption core.
// Signals : start      - request, sampled by the core only while idle
//           plaintext  - 128-bit block, byte 0 in bits [127:120]
//           key        - 128-bit cipher key, same byte order
//           busy       - block in flight
//           done       - one-cycle pulse, ciphertext valid
//           ciphertext - result, held until next done or reset
//           last_key   - final round key (only with AES_LAST_KEY_OUT_EN)
// Modports: master (requester) / slave (core).
// Macro   : AES_LAST_KEY_OUT_EN adds last_key.
// ---------------------------------------------------------------------------
interface aes128_encrypt_iter_if;
   logic         start;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         busy;
   logic         done;
   logic [127:0] ciphertext;
`ifdef AES_LAST_KEY_OUT_EN
   logic [127:0] last_key;

   modport master (output start, plaintext, key,
                   input  busy, done, ciphertext, last_key);
   modport slave  (input  start, plaintext, key,
                   output busy, done, ciphertext, last_key);
`else
   modport master (output start, plaintext, key,
                   input  busy, done, ciphertext);
   modport slave  (input  start, plaintext, key,
                   output busy, done, ciphertext);
`endif
endinterface

// File: rtl/aes128_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes128_encrypt_iter
// Purpose : iterative AES-128 encryption, one full round per clock with
//           on-the-fly key expansion. One block per 11-cycle transaction.
// Ports   : clk - clock, rising edge
//           rst - asynchronous active-high reset
//           bus - aes128_encrypt_iter_if.slave (start, plaintext, key,
//                 busy, done, ciphertext[, last_key])
// Macro   : AES_LAST_KEY_OUT_EN - also register and output rk_10 on
//           last_key, for the inverse key schedule.
// ---------------------------------------------------------------------------
module aes128_encrypt_iter (
   input  logic                  clk,
   input  logic                  rst,
   aes128_encrypt_iter_if.slave  bus
);

   localparam int unsigned NB_ROUNDS = 10;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // GF(2^8) multiply by x, modulus 0x11B
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Forward S-box computed as a^254 (inverse, 0 -> 0) then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (i != 0) r = gf_mul(r, a);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
               ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int n = 0; n < 16; n++)
         o[8*(15-n) +: 8] = sbox(s[8*(15-n) +: 8]);
      return o;
   endfunction

   // Byte n = 4*col + row; row r rotates left by r columns
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      int           src;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = 4 * ((c + r) % 4) + r;
            o[8*(15-(4*c+r)) +: 8] = s[8*(15-src) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[8*(15-4*c)   +: 8];
         a1 = s[8*(14-4*c)   +: 8];
         a2 = s[8*(13-4*c)   +: 8];
         a3 = s[8*(12-4*c)   +: 8];
         o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // One step of the AES-128 key schedule
   function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, t;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon, 24'h000000};
      w4 = w0 ^ t;
      w5 = w1 ^ w4;
      w6 = w2 ^ w5;
      w7 = w3 ^ w6;
      return {w4, w5, w6, w7};
   endfunction

   function automatic logic [7:0] rcon_of(input logic [3:0] k);
      case (k)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [0:0]   r_fsm;
   logic [3:0]   r_rcnt;
   logic [127:0] r_data;
   logic [127:0] r_key;
   logic         r_busy;
   logic         r_done;
   logic [127:0] r_ct;
`ifdef AES_LAST_KEY_OUT_EN
   logic [127:0] r_last_key;
   logic [127:0] w_last_key_nxt;
`endif

   logic [0:0]   w_fsm_nxt;
   logic [3:0]   w_rcnt_nxt;
   logic [127:0] w_data_nxt;
   logic [127:0] w_key_nxt;
   logic         w_busy_nxt;
   logic         w_done_nxt;
   logic [127:0] w_ct_nxt;

   logic [127:0] w_shift;
   logic [127:0] w_rk;

   // Round datapath, settles within one cycle
   assign w_shift = shift_rows(sub_bytes(r_data));
   assign w_rk    = expand_key(r_key, rcon_of(r_rcnt));

   // Next-state and next-output logic
   always_comb begin
      w_fsm_nxt  = r_fsm;
      w_rcnt_nxt = r_rcnt;
      w_data_nxt = r_data;
      w_key_nxt  = r_key;
      w_busy_nxt = r_busy;
      w_done_nxt = 1'b0;
      w_ct_nxt   = r_ct;
`ifdef AES_LAST_KEY_OUT_EN
      w_last_key_nxt = r_last_key;
`endif
      case (r_fsm)
         ST_IDLE: begin
            if (bus.start) begin
               w_data_nxt = bus.plaintext ^ bus.key;
               w_key_nxt  = bus.key;
               w_rcnt_nxt = 4'd1;
               w_busy_nxt = 1'b1;
               w_fsm_nxt  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_rcnt == 4'(NB_ROUNDS)) begin
               // Final round: no MixColumns
               w_ct_nxt   = w_shift ^ w_rk;
`ifdef AES_LAST_KEY_OUT_EN
               w_last_key_nxt = w_rk;
`endif
               w_data_nxt = w_shift ^ w_rk;
               w_key_nxt  = w_rk;
               w_rcnt_nxt = 4'd0;
               w_done_nxt = 1'b1;
               w_busy_nxt = 1'b0;
               w_fsm_nxt  = ST_IDLE;
            end else begin
               w_data_nxt = mix_columns(w_shift) ^ w_rk;
               w_key_nxt  = w_rk;
               w_rcnt_nxt = 4'(r_rcnt + 4'd1);
            end
         end
         default: begin
            w_fsm_nxt  = ST_IDLE;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm  <= ST_IDLE;
         r_rcnt <= 4'd0;
         r_data <= '0;
         r_key  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_ct   <= '0;
`ifdef AES_LAST_KEY_OUT_EN
         r_last_key <= '0;
`endif
      end else begin
         r_fsm  <= w_fsm_nxt;
         r_rcnt <= w_rcnt_nxt;
         r_data <= w_data_nxt;
         r_key  <= w_key_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_ct   <= w_ct_nxt;
`ifdef AES_LAST_KEY_OUT_EN
         r_last_key <= w_last_key_nxt;
`endif
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.ciphertext = r_ct;
`ifdef AES_LAST_KEY_OUT_EN
   assign bus.last_key   = r_last_key;
`endif

endmodule
